// File: rtl/id_ex_issue_pkg.sv
// Shared function-code constants and the EX register layout for the issue stage
// and the ALU control logic.
package id_ex_issue_pkg;

  localparam logic [5:0] FN_BUBBLE = 6'd0;
  localparam logic [5:0] FN_SRL    = 6'd2;
  localparam logic [5:0] FN_MFHI   = 6'd16;
  localparam logic [5:0] FN_MFLO   = 6'd18;
  localparam logic [5:0] FN_DIVU   = 6'd27;
  localparam logic [5:0] FN_ADD    = 6'd32;
  localparam logic [5:0] FN_SUB    = 6'd34;
  localparam logic [5:0] FN_AND    = 6'd36;
  localparam logic [5:0] FN_OR     = 6'd37;
  localparam logic [5:0] FN_SLT    = 6'd42;

  typedef struct packed {
    logic [5:0]  signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [4:0]  rd;
    logic        regWrite;
  } exReg_t;

  function automatic logic isDivu(input logic [5:0] funct);
    return funct == FN_DIVU;
  endfunction

endpackage

// File: rtl/id_ex_issue_if.sv
// Decode-to-EX bus: decoded operands in, EX register contents and stall status out.
interface id_ex_issue_if;

  logic        id_valid;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [4:0]  id_shamt;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        flush;
  logic        ex_hold;
  logic        id_stall;
  logic [5:0]  ex_signal;
  logic [31:0] ex_dataA;
  logic [31:0] ex_dataB;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        div_busy;

  modport master (
    output id_valid, id_funct, id_rs_data, id_rt_data, id_shamt, id_rd, id_reg_write,
           flush, ex_hold,
    input  id_stall, ex_signal, ex_dataA, ex_dataB, ex_rd, ex_reg_write, div_busy
  );

  modport slave (
    input  id_valid, id_funct, id_rs_data, id_rt_data, id_shamt, id_rd, id_reg_write,
           flush, ex_hold,
    output id_stall, ex_signal, ex_dataA, ex_dataB, ex_rd, ex_reg_write, div_busy
  );

endinterface

// File: rtl/id_ex_issue_div_window_counter.sv
// Down-counter covering the divider's busy window; cannot be aborted once loaded.
module div_window_counter #(
  parameter int DIV_CYCLES = 37,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               count <= '0;
    else if (load)            count <= CNT_W'(DIV_CYCLES);
    else if (count != '0)     count <= count - CNT_W'(1);
  end

  assign busy = (count != '0);

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue register with divider structural-hazard interlock, flush and hold.
module id_ex_issue
  import id_ex_issue_pkg::*;
#(
  parameter int DIV_CYCLES = 37,
  parameter int CNT_W      = 6
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_issue_if.slave  bus
);

  exReg_t           exQ;
  exReg_t           decoded;
  logic             divBusy;
  logic             divLoad;
  logic [CNT_W-1:0] busyCnt;

  // ALU complex swaps SRL operands itself, so shamt goes on A unswapped.
  always_comb begin
    decoded          = '0;
    decoded.signal   = bus.id_funct;
    decoded.dataA    = (bus.id_funct == FN_SRL) ? {27'b0, bus.id_shamt} : bus.id_rs_data;
    decoded.dataB    = bus.id_rt_data;
    decoded.rd       = bus.id_rd;
    decoded.regWrite = bus.id_reg_write & ~isDivu(bus.id_funct);
  end

  // A DIVU opens the window only when it actually lands in EX.
  assign divLoad = bus.id_valid & isDivu(bus.id_funct) & ~bus.flush & ~bus.ex_hold & ~divBusy;

  div_window_counter #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) uDivWin (
    .clk   (clk),
    .reset (reset),
    .load  (divLoad),
    .busy  (divBusy),
    .count (busyCnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             exQ <= '0;
    else if (bus.flush)     exQ <= '0;
    else if (bus.ex_hold)   exQ <= exQ;
    else if (divBusy)       exQ <= '0;
    else if (bus.id_valid)  exQ <= decoded;
    else                    exQ <= '0;
  end

  assign bus.ex_signal    = exQ.signal;
  assign bus.ex_dataA     = exQ.dataA;
  assign bus.ex_dataB     = exQ.dataB;
  assign bus.ex_rd        = exQ.rd;
  assign bus.ex_reg_write = exQ.regWrite;
  assign bus.div_busy     = divBusy;
  assign bus.id_stall     = divBusy | bus.ex_hold;

  busyMatchesCount: assert property (@(posedge clk) disable iff (!reset)
    divBusy == (busyCnt != '0));

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

ID/EX issue stage for the pipelined CPU. It registers decoded operands and the 6-bit function code from the decode stage and drives them into the EX-stage ALU complex on the next cycle. It also owns the only structural hazard in EX: the multi-cycle unsigned divider. A DIVU is presented to EX for exactly one cycle, then EX receives bubbles and decode is stalled until the divider window has elapsed. The block also supports branch flush and a downstream hold.

## Interface
Parameters:
- DIV_CYCLES, 37, cycles decode stays stalled after a DIVU enters EX; must be ≥ the divider's internal iteration count plus one.
- CNT_W, 6, width of the busy counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion.
- id_valid  in  1  decode holds a real instruction.
- id_funct  in  6  function code (AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, DIVU 27, MFHI 16, MFLO 18).
- id_rs_data  in  32  rs operand.
- id_rt_data  in  32  rt operand.
- id_shamt  in  5  shift amount.
- id_rd  in  5  destination register.
- id_reg_write  in  1  instruction writes the register file.
- flush  in  1  branch redirect; kill the instruction being captured.
- ex_hold  in  1  downstream stall; freeze the EX register.
- id_stall  out  1  decode must hold its current instruction.
- ex_signal  out  6  function code to the ALU complex; 0 = bubble.
- ex_dataA  out  32  operand A.
- ex_dataB  out  32  operand B.
- ex_rd  out  5  destination register.
- ex_reg_write  out  1  write enable travelling with the instruction.
- div_busy  out  1  divider window active.

## Operation
- EX register fields: signal, dataA, dataB, rd, reg_write. A bubble is all fields zero.
- Operand mapping:
  - SRL: dataA = {27'b0, id_shamt}, dataB = id_rt_data.
  - All other functions: dataA = id_rs_data, dataB = id_rt_data.
- The ALU complex performs its own SRL operand swap, so this block must not swap.
- DIVU forces reg_write = 0. HI/LO are written inside the EX stage, not through the register file.
- id_valid = 0 captures a bubble.
- EX register update priority at each edge, highest first:
  1. flush: load bubble.
  2. ex_hold: keep the current contents.
  3. busy_cnt ≠ 0: load bubble.
  4. Otherwise: load the decoded instruction.
- Busy counter behaviour:
  - Loads DIV_CYCLES at the edge where a DIVU is loaded into EX.
  - Otherwise decrements every cycle while nonzero.
  - It runs regardless of flush and ex_hold, because the divider cannot be aborted.
  - A flush does not cancel an already-loaded divide window.
  - A DIVU that is itself flushed never loads the counter.
- div_busy = (busy_cnt ≠ 0).
- id_stall = div_busy OR ex_hold. It is combinational from registered state plus ex_hold.
- MFHI/MFLO need no extra interlock: they cannot issue until the divide window closes.

## Timing
- Reset values: ex_signal 0, ex_dataA 0, ex_dataB 0, ex_rd 0, ex_reg_write 0, busy_cnt 0, div_busy 0. id_stall equals ex_hold.
- Latency: an instruction captured at edge E is on the ex_* outputs from E until the next update.
- DIVU issue sequence (edge E0 loads the DIVU):
  - Cycle E0→E1: ex_signal = 27, id_stall = 1.
  - Edges E1 through E(DIV_CYCLES−1): EX loads bubbles.
  - After edge E(DIV_CYCLES): busy_cnt = 0 and id_stall = 0.
  - The next instruction is loaded at edge E(DIV_CYCLES+1).
- Back-to-back DIVU: the second DIVU waits in decode for the full window, then issues normally.
- ex_hold during a DIVU's first cycle: ex_signal stays 27 for extra cycles. The counter still decrements.
- Reset asserted mid-divide: counter and EX register clear asynchronously. After release, issue resumes with no stall.

## Structure
- A shared package holds the function-code constants (FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL, FN_DIVU, FN_MFHI, FN_MFLO) and FN_BUBBLE = 0. The ALU control logic uses the same package.
- One sub-module: div_window_counter.
  - Inputs: load, clk, reset.
  - Outputs: busy, count.
  - Parameterised by DIV_CYCLES and CNT_W.
- The EX register and priority mux stay in the top level.

## Test plan
- Reset release, then ADD with rs=5, rt=7, rd=3 → next cycle ex_signal=32, dataA=5, dataB=7, ex_rd=3, ex_reg_write=1.
- SRL with shamt=4, rt=0x80 → ex_dataA=4, ex_dataB=0x80, ex_signal=2.
- DIVU 100/7 followed by MFLO:
  - ex_signal=27 for exactly 1 cycle.
  - id_stall high for DIV_CYCLES cycles (37).
  - MFLO appears on ex_signal=18 at edge 38 after the DIVU load.
- flush asserted together with a captured DIVU → EX holds a bubble, div_busy never rises, no stall.
- ex_hold for 3 cycles with SUB in EX → ex_* outputs unchanged and id_stall=1 for those 3 cycles. Then the next instruction loads.
- reset pulsed low 10 cycles into a divide window → div_busy=0 and all ex_* outputs 0 immediately. After release, an ADD issues with no stall.
